// File: rtl/inc_share_arbiter.sv
// Round-robin arbiter that shares one INC (a+1) unit among NUM_REQ requesters.
// One operand in via valid/ready, result back with requester ID via valid/ready.
module inc_share_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [DATAWIDTH-1:0]           o_inc_a,
    input  logic [DATAWIDTH-1:0]           i_inc_d,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [IDW-1:0]                 o_rsp_id,
    output logic [DATAWIDTH-1:0]           o_rsp_data,
    output logic                           o_rsp_wrap,
    output logic                           o_busy
);

    // state | meaning
    // IDLE  | granting: one-hot ready toward the first valid requester from ptr
    // CALC  | operand registered on inc_a; INC output settling
    // HOLD  | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDW-1:0]         r_ptr;
    logic [IDW-1:0]         r_rsp_id;
    logic [DATAWIDTH-1:0]   r_inc_a;
    logic [DATAWIDTH-1:0]   r_rsp_data;
    logic                   r_rsp_wrap;
    logic                   r_rsp_valid;

    logic [DATAWIDTH-1:0]   w_req_arr [NUM_REQ];
    logic                   w_gnt_any;
    logic [IDW-1:0]         w_gnt_idx;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_xfer;
    logic                   w_rsp_done;
    logic [IDW-1:0]         w_ptr_nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_arr[g] = i_req_data[g*DATAWIDTH +: DATAWIDTH];
    end

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % NUM_REQ);
    endfunction

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[rr_index(r_ptr, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = rr_index(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if ((r_state == IDLE) && w_gnt_any && !i_rst) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_xfer     = (r_state == IDLE) && w_gnt_any;
    assign w_rsp_done = (r_state == HOLD) && r_rsp_valid && i_rsp_ready;
    assign w_ptr_nxt  = (r_rsp_id == IDW'(NUM_REQ - 1)) ? '0 : r_rsp_id + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_state_nxt = CALC;
            CALC:    w_state_nxt = HOLD;
            HOLD:    if (w_rsp_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // inc_a moves only on a transfer, keeping the INC output steady through CALC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_inc_a     <= '0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_wrap  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_inc_a  <= w_req_arr[w_gnt_idx];
                r_rsp_id <= w_gnt_idx;
            end
            if (r_state == CALC) begin
                r_rsp_data  <= i_inc_d;
                r_rsp_wrap  <= &r_inc_a;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_ptr       <= w_ptr_nxt;
            end
        end
    end

    assign o_req_ready = w_ready;
    assign o_inc_a     = r_inc_a;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_wrap  = r_rsp_wrap;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_inc_share_arbiter.sv
// Directed bench for inc_share_arbiter with a behavioural INC (a+1) on the side.
module tb_inc_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  inc_a;
    logic [7:0]  inc_d;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_wrap;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    inc_share_arbiter #(.DATAWIDTH(8), .NUM_REQ(4), .IDW(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_inc_a     (inc_a),
        .i_inc_d     (inc_d),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data),
        .o_rsp_wrap  (rsp_wrap),
        .o_busy      (busy)
    );

    assign inc_d = inc_a + 8'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] d, input logic w);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_wrap"},  32'(rsp_wrap),  32'(w));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'd0;
        rsp_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_inc_a", 32'(inc_a),     0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_data",  32'(rsp_data),  0);
        step();
        rst = 1'b0;
        #1;

        // single request
        set_data(0, 8'd10);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0001);
        chk("t1_idle_busy", 32'(busy), 0);
        step();
        chk("t1_calc_ready", 32'(req_ready), 0);
        chk("t1_calc_busy",  32'(busy), 1);
        chk("t1_inc_a",      32'(inc_a), 10);
        chk("t1_calc_valid", 32'(rsp_valid), 0);
        req_valid = 4'b0000;
        step();
        chk_rsp("t1", 2'd0, 8'd11, 1'b0);
        step();
        chk("t1_done_valid", 32'(rsp_valid), 0);
        chk("t1_done_busy",  32'(busy), 0);

        // wrap on requester 2 (ptr is 1 now)
        set_data(2, 8'd255);
        req_valid = 4'b0100;
        #1;
        chk("t2_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        step();
        chk_rsp("t2", 2'd2, 8'd0, 1'b1);
        step();

        // reset so round-robin starts from requester 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;

        // round-robin with all requesters asserted
        for (int i = 0; i < 4; i++) set_data(i, 8'(20 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk("t3_calc_valid", 32'(rsp_valid), 0);
            step();
            chk_rsp("t3", 2'(k % 4), 8'(21 + (k % 4)), 1'b0);
            step();
        end
        req_valid = 4'b0000;
        #1;

        // backpressure on requester 1 (ptr is 1 after serving 0)
        set_data(1, 8'd7);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("t4_ready", 32'(req_ready), 32'b0010);
        step();
        set_data(3, 8'd99);
        req_valid = 4'b1000;
        step();
        for (int c = 0; c < 5; c++) begin
            chk_rsp("t4_hold", 2'd1, 8'd8, 1'b0);
            chk("t4_hold_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("t4_done_valid", 32'(rsp_valid), 0);
        chk("t4_next_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        step();
        chk_rsp("t4_next", 2'd3, 8'd100, 1'b0);
        step();

        // serve requester 1 so ptr becomes 2, then reset during CALC of requester 3
        set_data(1, 8'd5);
        req_valid = 4'b0010;
        #1;
        step();
        req_valid = 4'b0000;
        step();
        step();
        set_data(3, 8'd50);
        req_valid = 4'b1000;
        #1;
        step();
        chk("t5_calc_inc_a", 32'(inc_a), 50);
        chk("t5_calc_busy",  32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(rsp_valid), 0);
        chk("t5_rst_inc_a", 32'(inc_a), 0);
        chk("t5_rst_busy",  32'(busy), 0);
        chk("t5_rst_ready", 32'(req_ready), 0);
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b0;
        #1;
        step();
        chk("t5_no_rsp", 32'(rsp_valid), 0);
        req_valid = 4'b1010;
        #1;
        chk("t5_ptr0_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0000;
        step();
        chk_rsp("t5", 2'd1, 8'd6, 1'b0);
        step();

        // late arrivals during HOLD of requester 0 (ptr is 2)
        set_data(0, 8'd0);
        set_data(1, 8'd30);
        set_data(3, 8'd40);
        req_valid = 4'b0001;
        #1;
        chk("t6_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b1010;
        #1;
        chk("t6_hold_ready", 32'(req_ready), 0);
        chk_rsp("t6_r0", 2'd0, 8'd1, 1'b0);
        step();
        rsp_ready = 1'b1;
        step();
        chk("t6_ready1", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1000;
        step();
        chk_rsp("t6_r1", 2'd1, 8'd31, 1'b0);
        step();
        chk("t6_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        step();
        chk_rsp("t6_r3", 2'd3, 8'd41, 1'b0);
        step();
        chk("t6_end_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
